fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction fetch stage plus IF/ID pipeline register, directly upstream of the main control decoder.
- Holds the PC and issues word reads to instruction memory through a req/ready handshake.
- Registers the returned instruction and PC+4, and drives opcode[5:0] into the decoder's control input and funct[5:0] toward ALU control.
- Accepts branch redirects from EX and stalls from hazard logic.

Parameters:
- PC_WIDTH, 32, width of PC, addresses and pc4 outputs.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  PC_WIDTH  word address of the request (= pc).
- imem_rdata  in  32  instruction data; valid when imem_ready=1.
- imem_ready  in  1  memory accepts and completes the request this cycle.
- stall  in  1  hold IF/ID contents and PC.
- branch_taken  in  1  redirect request (branch & zero from EX).
- branch_target  in  PC_WIDTH  redirect address.
- ifid_valid  out  1  IF/ID holds a real instruction.
- ifid_instr  out  32  registered instruction; 0 (NOP) when invalid.
- ifid_pc4  out  PC_WIDTH  PC of that instruction + 4.
- opcode  out  6  ifid_instr[31:26], to control decoder.
- funct  out  6  ifid_instr[5:0], to ALU control.

Behaviour:
- Interface is one clock; reset is synchronous and active-low.
- States: FETCH, HOLD.
- Reset (rst_n=0 at an edge):
  - state=FETCH, pc=RESET_PC, buffer empty.
  - ifid_valid=0, ifid_instr=0, ifid_pc4=0.
  - Reset overrides all inputs and aborts any outstanding request; no response is retained.
- Outputs:
  - imem_req=1 only in FETCH while rst_n=1; imem_req=0 in HOLD.
  - imem_addr=pc at all times.
  - opcode and funct are combinational slices of ifid_instr, so they read 0 after reset.
- FETCH, imem_ready=1, stall=0:
  - IF/ID <= {valid=1, instr=imem_rdata, pc4=pc+4}; pc <= pc+4.
  - Zero-bubble throughput: 1 instruction per cycle when memory is always ready.
- FETCH, imem_ready=1, stall=1:
  - imem_rdata and pc+4 are captured into a one-entry skid buffer; pc <= pc+4; state <= HOLD.
  - IF/ID is unchanged.
- FETCH, imem_ready=0:
  - If stall=0, IF/ID <= {valid=0, instr=0}; ifid_pc4 is unchanged (bubble).
  - If stall=1, IF/ID is unchanged. pc is unchanged.
- HOLD:
  - stall=1: everything is held.
  - stall=0: IF/ID <= buffer (valid=1); state <= FETCH.
- Redirect:
  - branch_taken=1 has priority over stall and imem_ready.
  - pc <= {branch_target[PC_WIDTH-1:2], 2'b00}; IF/ID <= {valid=0, instr=0}.
  - Skid buffer is discarded; state <= FETCH.
  - Any same-cycle imem_rdata is dropped.
  - First fetch from the target occurs the next cycle (1 bubble minimum).
- Arithmetic: pc+4 is modulo 2^PC_WIDTH, so 32'hFFFF_FFFC wraps to 32'h0000_0000. No alignment exception is raised.
- Latency: instruction returned at edge N is visible on opcode/funct after edge N (registered, 1 cycle).

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count (32) and output bubble_count (32), both reset to 0 synchronously.
  - fetch_count increments on every cycle an instruction is written into IF/ID or the skid buffer.
  - bubble_count increments on every edge where IF/ID is loaded with valid=0 (memory wait or redirect).
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset then imem_ready=1 constant, imem_rdata=32'h8C01_0004 → first edge after reset release: ifid_valid=1, opcode=6'b100011, ifid_pc4=4, imem_addr=4.
- imem_ready low for 3 cycles, then high with rdata=32'h0000_0020 → 3 bubbles (ifid_valid=0, opcode=0), then funct=6'b100000, pc advances by exactly 4.
- stall=1 for 2 cycles while imem_ready=1 (rdata A then B) → IF/ID keeps prior instr, imem_req=0 during HOLD; after release A appears, then B is fetched from pc+4 (no loss, no duplicate).
- branch_taken=1 with branch_target=32'h0000_0043, simultaneous with stall=1 and imem_ready=1 → next cycle pc=32'h0000_0040, ifid_valid=0, skid buffer empty.
- RESET_PC=32'hFFFF_FFFC, one fetch → ifid_pc4=0, imem_addr=0.
- rst_n=0 asserted during HOLD → next edge ifid_valid=0, imem_addr=RESET_PC, state FETCH; with FETCH_PERF_EN, fetch_count=0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch plus IF/ID pipeline register.
// Holds the PC, issues word reads over a req/ready handshake, and registers
// the returned instruction with PC+4 for the control decoder and ALU control.
// A one-entry skid buffer keeps a word that returns during a stall.
// Optional feature: define FETCH_PERF_EN to add fetch_count/bubble_count.
//
// state | meaning
// FETCH | request issued every cycle at pc
// HOLD  | skid buffer full, waiting for stall to drop; no request
module fetch_stage #(
    parameter int                    PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_ready,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                ifid_valid,
    output logic [31:0]         ifid_instr,
    output logic [PC_WIDTH-1:0] ifid_pc4,
    output logic [5:0]          opcode,
    output logic [5:0]          funct
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         bubble_count
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         skid_instr;
    logic [PC_WIDTH-1:0] skid_pc4;
    logic [PC_WIDTH-1:0] pc_next4;
    logic [PC_WIDTH-1:0] target_aligned;

    // Wraps modulo 2^PC_WIDTH; the low two target bits are forced to zero.
    assign pc_next4       = pc + PC_WIDTH'(4);
    assign target_aligned = branch_target & {{(PC_WIDTH-2){1'b1}}, 2'b00};

    assign imem_req  = (state == FETCH) && rst_n;
    assign imem_addr = pc;
    assign opcode    = ifid_instr[31:26];
    assign funct     = ifid_instr[5:0];

    // PC, FSM, skid buffer and IF/ID register; redirect beats stall and ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            skid_instr <= 32'h0;
            skid_pc4   <= {PC_WIDTH{1'b0}};
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
            ifid_pc4   <= {PC_WIDTH{1'b0}};
        end else if (branch_taken) begin
            state      <= FETCH;
            pc         <= target_aligned;
            ifid_valid <= 1'b0;
            ifid_instr <= 32'h0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        pc <= pc_next4;
                        if (stall) begin
                            skid_instr <= imem_rdata;
                            skid_pc4   <= pc_next4;
                            state      <= HOLD;
                        end else begin
                            ifid_valid <= 1'b1;
                            ifid_instr <= imem_rdata;
                            ifid_pc4   <= pc_next4;
                        end
                    end else if (!stall) begin
                        ifid_valid <= 1'b0;
                        ifid_instr <= 32'h0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        ifid_valid <= 1'b1;
                        ifid_instr <= skid_instr;
                        ifid_pc4   <= skid_pc4;
                        state      <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_evt;
    logic bubble_evt;

    assign fetch_evt  = rst_n && !branch_taken && (state == FETCH) && imem_ready;
    assign bubble_evt = rst_n && (branch_taken ||
                        ((state == FETCH) && !imem_ready && !stall));

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count  <= 32'h0;
            bubble_count <= 32'h0;
        end else begin
            if (fetch_evt && (fetch_count != 32'hFFFF_FFFF))
                fetch_count <= fetch_count + 32'd1;
            if (bubble_evt && (bubble_count != 32'hFFFF_FFFF))
                bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule
